// File: rtl/reg_loader.sv
// reg_loader: upstream feeder for the 8-slot value register bank.
// 4-bit values arrive on a valid/ready stream and are buffered in a small FIFO.
// Each buffered value is written into the next bank slot (0..SLOTS-1) as a one-cycle setd strobe.
// Lookup requests are arbitrated onto D_lookup and marked by a one-cycle lookup_go strobe.
// Lookups take priority over writes.
// Ports:
//   clk, init (async active-high reset), clear (synchronous flush)
//   in_valid/in_data/in_ready    value stream into the FIFO
//   lk_valid/lk_key/lk_ready     lookup request stream
//   setd/newd/slot               registered bank write strobe, data and slot index
//   D_lookup/lookup_go           registered lookup key and its one-cycle strobe
//   count/full/busy              write progress and activity status
module reg_loader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SLOTS = 8
) (
    input  logic       clk,
    input  logic       init,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       lk_valid,
    input  logic [3:0] lk_key,
    output logic       lk_ready,
    output logic       setd,
    output logic [3:0] newd,
    output logic [2:0] slot,
    output logic [3:0] D_lookup,
    output logic       lookup_go,
    output logic [3:0] count,
    output logic       full,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [3:0]    SLOTS_C = 4'(SLOTS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] LOOK  = 2'd2;
    localparam logic [1:0] FULL  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          push, pop, lk_acc;

    // FIFO handshake; init and clear both refuse new data
    assign in_ready = !init && !clear && (occ != DEPTH_C);
    assign push     = in_valid && in_ready;
    assign lk_ready = lk_acc && !init;
    assign busy     = (occ != OW'(0)) || (state != IDLE);

    // Next-state and pop/accept decisions
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        lk_acc   = 1'b0;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (lk_valid) begin
                        lk_acc   = 1'b1;
                        state_nx = LOOK;
                    end else if ((occ != OW'(0)) && (count < SLOTS_C)) begin
                        pop      = 1'b1;
                        state_nx = WRITE;
                    end else if (count == SLOTS_C) begin
                        state_nx = FULL;
                    end
                end
                WRITE: state_nx = IDLE;
                // A lookup served while full goes straight back to FULL
                LOOK:  state_nx = (count == SLOTS_C) ? FULL : IDLE;
                FULL: begin
                    if (lk_valid) begin
                        lk_acc   = 1'b1;
                        state_nx = LOOK;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge init) begin
        if (init) state <= IDLE;
        else      state <= state_nx;
    end

    // FIFO storage (data needs no reset; occupancy guards validity)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Slot counter: advances at the end of each WRITE cycle, saturating at SLOTS
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            count <= 4'd0;
            full  <= 1'b0;
        end else if (clear) begin
            count <= 4'd0;
            full  <= 1'b0;
        end else if ((state == WRITE) && (count < SLOTS_C)) begin
            count <= count + 4'd1;
            full  <= ((count + 4'd1) == SLOTS_C);
        end
    end

    // Registered bank-side strobes; D_lookup survives clear
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            setd      <= 1'b0;
            newd      <= 4'd0;
            slot      <= 3'd0;
            lookup_go <= 1'b0;
            D_lookup  <= 4'd0;
        end else if (clear) begin
            setd      <= 1'b0;
            lookup_go <= 1'b0;
        end else begin
            setd      <= pop;
            lookup_go <= lk_acc;
            if (pop) begin
                newd <= mem[rd_ptr];
                slot <= count[2:0];
            end
            if (lk_acc) D_lookup <= lk_key;
        end
    end

endmodule

// File: tb/tb_reg_loader.sv
// Directed testbench for reg_loader: one task per scenario with inline checks.
module tb_reg_loader;

    logic       clk;
    logic       init;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       lk_valid;
    logic [3:0] lk_key;
    logic       lk_ready;
    logic       setd;
    logic [3:0] newd;
    logic [2:0] slot;
    logic [3:0] D_lookup;
    logic       lookup_go;
    logic [3:0] count;
    logic       full;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_loader #(.DEPTH(4), .SLOTS(8)) dut (
        .clk      (clk),
        .init     (init),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .lk_valid (lk_valid),
        .lk_key   (lk_key),
        .lk_ready (lk_ready),
        .setd     (setd),
        .newd     (newd),
        .slot     (slot),
        .D_lookup (D_lookup),
        .lookup_go(lookup_go),
        .count    (count),
        .full     (full),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init = 1'b1; clear = 1'b0; in_valid = 1'b0; lk_valid = 1'b0;
        in_data = 4'd0; lk_key = 4'd0;
        tick(); tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        init = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 4'd7;
        lk_valid = 1'b1; lk_key = 4'd3;
        #3;
        n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (lk_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_lk_ready: got %b want 0", lk_ready); end
        n_cmp++; if (setd !== 1'b0)      begin n_fail++; $display("FAIL rst_setd: got %b want 0", setd); end
        n_cmp++; if (count !== 4'd0)     begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0)      begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (lookup_go !== 1'b0) begin n_fail++; $display("FAIL rst_lookup_go: got %b want 0", lookup_go); end
        n_cmp++; if (D_lookup !== 4'd0)  begin n_fail++; $display("FAIL rst_D_lookup: got %0d want 0", D_lookup); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_data = 4'd3;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        tick();
        in_data = 4'd9;
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd0, 4'd3}) begin n_fail++; $display("FAIL b2b_w0: got setd=%b slot=%0d newd=%0d want 1/0/3", setd, slot, newd); end
        in_data = 4'd12;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (setd !== 1'b0) begin n_fail++; $display("FAIL b2b_gap0: got setd=%b want 0", setd); end
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd1, 4'd9}) begin n_fail++; $display("FAIL b2b_w1: got setd=%b slot=%0d newd=%0d want 1/1/9", setd, slot, newd); end
        tick();
        n_cmp++; if (setd !== 1'b0) begin n_fail++; $display("FAIL b2b_gap1: got setd=%b want 0", setd); end
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd2, 4'd12}) begin n_fail++; $display("FAIL b2b_w2: got setd=%b slot=%0d newd=%0d want 1/2/12", setd, slot, newd); end
        tick();
        n_cmp++; if (setd !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got setd=%b want 0", setd); end
        n_cmp++; if (count !== 4'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", count); end
        n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_lookup_priority();
        do_reset();
        in_valid = 1'b1; in_data = 4'd6;
        tick();
        in_valid = 1'b0; lk_valid = 1'b1; lk_key = 4'd5;
        #1;
        n_cmp++; if (lk_ready !== 1'b1) begin n_fail++; $display("FAIL lkp_ready: got %b want 1", lk_ready); end
        tick();
        n_cmp++; if ({lookup_go, D_lookup, setd} !== {1'b1, 4'd5, 1'b0}) begin n_fail++; $display("FAIL lkp_go: got go=%b key=%0d setd=%b want 1/5/0", lookup_go, D_lookup, setd); end
        #1;
        n_cmp++; if (lk_ready !== 1'b0) begin n_fail++; $display("FAIL lkp_ready_in_look: got %b want 0", lk_ready); end
        lk_valid = 1'b0;
        tick();
        n_cmp++; if ({lookup_go, setd, D_lookup} !== {1'b0, 1'b0, 4'd5}) begin n_fail++; $display("FAIL lkp_after: got go=%b setd=%b key=%0d want 0/0/5", lookup_go, setd, D_lookup); end
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd0, 4'd6}) begin n_fail++; $display("FAIL lkp_write: got setd=%b slot=%0d newd=%0d want 1/0/6", setd, slot, newd); end
        tick();
        n_cmp++; if ({setd, count} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL lkp_count: got setd=%b count=%0d want 0/1", setd, count); end
    endtask

    task automatic test_clear();
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 4'(i);
            tick();
        end
        // WRITE of value 2 into slot 1, values 3 and 4 buffered
        n_cmp++; if ({setd, slot, newd, count} !== {1'b1, 3'd1, 4'd2, 4'd1}) begin n_fail++; $display("FAIL clr_pre: got setd=%b slot=%0d newd=%0d count=%0d want 1/1/2/1", setd, slot, newd, count); end
        clear = 1'b1; in_data = 4'd5; lk_valid = 1'b1; lk_key = 4'd8;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (lk_ready !== 1'b0) begin n_fail++; $display("FAIL clr_lk_ready: got %b want 0", lk_ready); end
        tick();
        clear = 1'b0; in_valid = 1'b0; lk_valid = 1'b0;
        n_cmp++; if ({setd, lookup_go, count, busy} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL clr_post: got setd=%b go=%b count=%0d busy=%b want 0/0/0/0", setd, lookup_go, count, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (setd !== 1'b0) begin n_fail++; $display("FAIL clr_idle%0d: got setd=%b want 0", i, setd); end
        end
        in_valid = 1'b1; in_data = 4'd9;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd0, 4'd9}) begin n_fail++; $display("FAIL clr_rewrite: got setd=%b slot=%0d newd=%0d want 1/0/9", setd, slot, newd); end
    endtask

    task automatic test_fill();
        logic [3:0] vals [10] = '{4'd2, 4'd5, 4'd8, 4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13};
        int  np = 0;
        int  nw = 0;
        int  extra = 0;
        logic prev_setd = 1'b0;
        logic saw_stall = 1'b0;
        logic acc;
        do_reset();
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (np < 10) begin in_valid = 1'b1; in_data = vals[np]; end
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            tick();
            if (acc) np++;
            if (setd) begin
                n_cmp++;
                if (nw >= 8) begin n_fail++; $display("FAIL fill_extra_write: got setd=1 after %0d writes want 0", nw); end
                else if (slot !== 3'(nw) || newd !== vals[nw]) begin n_fail++; $display("FAIL fill_w%0d: got slot=%0d newd=%0d want %0d/%0d", nw, slot, newd, nw, vals[nw]); end
                n_cmp++; if (prev_setd) begin n_fail++; $display("FAIL fill_spacing%0d: got consecutive setd want gap", nw); end
                nw++;
            end
            prev_setd = setd;
        end
        in_valid = 1'b0;
        n_cmp++; if (np !== 10) begin n_fail++; $display("FAIL fill_pushed: got %0d want 10", np); end
        n_cmp++; if (nw !== 8)  begin n_fail++; $display("FAIL fill_writes: got %0d want 8", nw); end
        n_cmp++; if ({count, full, busy} !== {4'd8, 1'b1, 1'b1}) begin n_fail++; $display("FAIL fill_status: got count=%0d full=%b busy=%b want 8/1/1", count, full, busy); end
        n_cmp++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall: got in_ready never low want a stall at DEPTH"); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_room: got in_ready=%b want 1", in_ready); end
        // FIFO holds 2, so exactly 2 more fit while FULL
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            #1;
            if (in_ready) extra++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (extra !== 2) begin n_fail++; $display("FAIL fill_topup: got %0d accepted want 2", extra); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_fifo_full: got in_ready=%b want 0", in_ready); end
    endtask

    task automatic test_full_lookup();
        lk_valid = 1'b1; lk_key = 4'd15;
        #1;
        n_cmp++; if (lk_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b want 1", lk_ready); end
        tick();
        n_cmp++; if ({lookup_go, D_lookup, setd} !== {1'b1, 4'd15, 1'b0}) begin n_fail++; $display("FAIL fl_go: got go=%b key=%0d setd=%b want 1/15/0", lookup_go, D_lookup, setd); end
        #1;
        n_cmp++; if (lk_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready_in_look: got %b want 0", lk_ready); end
        lk_valid = 1'b0;
        tick();
        n_cmp++; if (lookup_go !== 1'b0) begin n_fail++; $display("FAIL fl_go_end: got %b want 0", lookup_go); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (setd !== 1'b0) begin n_fail++; $display("FAIL fl_nowrite%0d: got setd=%b want 0", i, setd); end
        end
        n_cmp++; if ({count, full, busy, D_lookup} !== {4'd8, 1'b1, 1'b1, 4'd15}) begin n_fail++; $display("FAIL fl_status: got count=%0d full=%b busy=%b key=%0d want 8/1/1/15", count, full, busy, D_lookup); end
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        // From FULL: reset mid-cycle clears status without a clock edge
        #2;
        init = 1'b1; lk_valid = 1'b1;
        #1;
        n_cmp++; if ({full, count, busy} !== {1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL ar_full: got full=%b count=%0d busy=%b want 0/0/0", full, count, busy); end
        n_cmp++; if ({in_ready, lk_ready} !== 2'b00) begin n_fail++; $display("FAIL ar_ready: got in_ready=%b lk_ready=%b want 0/0", in_ready, lk_ready); end
        lk_valid = 1'b0;
        tick();
        init = 1'b0;
        tick();
        // Mid-stream: kill an in-flight strobe
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (setd && slot == 3'd1) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL ar_wait: got no write to slot 1 within 20 cycles want one"); end
        #2;
        init = 1'b1;
        #1;
        n_cmp++; if ({setd, count, full} !== {1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL ar_midstream: got setd=%b count=%0d full=%b want 0/0/0", setd, count, full); end
        tick();
        init = 1'b0;
        in_valid = 1'b1; in_data = 4'd7;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if ({setd, slot, newd} !== {1'b1, 3'd0, 4'd7}) begin n_fail++; $display("FAIL ar_first: got setd=%b slot=%0d newd=%0d want 1/0/7", setd, slot, newd); end
        tick();
        n_cmp++; if ({setd, count} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL ar_count: got setd=%b count=%0d want 0/1", setd, count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lookup_priority();
        test_clear();
        test_fill();
        test_full_lookup();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
